hdng_pid: RTL and testbench

- Heading controller feeding the motor-driver stage.
- On each heading sample, computes a wrapped heading error and a PID correction, and maintains a ramped forward speed.
- Outputs signed left/right wheel speed commands (`lft_spd`, `rght_spd`). These go straight to the motor driver, which applies battery scaling and PWM generation.
- Pipelined, 3-cycle sample-to-command latency, one new sample accepted per clock.

---
 rtl/hdng_pid.sv | 152 +++++++++++++++
 tb/tb_hdng_pid.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/hdng_pid.sv
// Heading PID controller: wrapped heading error -> P/I/D correction -> left/right wheel commands.
// Optional derivative path enabled by defining HDNG_PID_DTERM_EN; 3-cycle sample-to-command pipeline.
module hdng_pid #(
  parameter logic [10:0] FRWRD_MAX   = 11'h2A0,
  parameter logic [7:0]  FRWRD_INC   = 8'h18,
  parameter logic [3:0]  P_COEFF     = 4'h3,
  parameter logic [3:0]  D_COEFF     = 4'h6,
  parameter logic [8:0]  AT_HDNG_THR = 9'h030
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        moving,
  input  logic        hdng_vld,
  input  logic [11:0] dsrd_hdng,
  input  logic [11:0] actl_hdng,
  output logic [11:0] lft_spd,
  output logic [11:0] rght_spd,
  output logic        spd_vld,
  output logic        at_hdng
);

  // Stage registers
  logic               v1, v2;
  logic               mv1, mv2;
  logic signed [9:0]  err1;
  logic [10:0]        frwrd, f2;
  logic signed [13:0] p_reg;
  logic signed [11:0] d_reg;
  logic signed [15:0] integ;

  // Stage 1: wrapped error, saturation, threshold, forward ramp
  logic signed [11:0] err12;
  logic [12:0]        err_abs;
  logic signed [9:0]  err_sat;
  logic               at_nxt;
  logic [11:0]        frwrd_up, frwrd_step;
  logic [10:0]        frwrd_nxt;

  always_comb begin
    err12      = signed'(actl_hdng - dsrd_hdng);
    err_abs    = err12[11] ? 13'(-13'(err12)) : 13'(err12);
    at_nxt     = err_abs < 13'(AT_HDNG_THR);
    err_sat    = err12[9:0];
    if (err12 > 12'sd511)       err_sat = 10'sd511;
    else if (err12 < -12'sd512) err_sat = -10'sd512;
    frwrd_up   = 12'(frwrd) + 12'(FRWRD_INC);
    frwrd_step = 12'(FRWRD_INC) << 1;
    if (moving)
      frwrd_nxt = (frwrd_up > 12'(FRWRD_MAX)) ? FRWRD_MAX : frwrd_up[10:0];
    else
      frwrd_nxt = (12'(frwrd) < frwrd_step) ? 11'd0 : 11'(12'(frwrd) - frwrd_step);
  end

  // Stage 2: proportional product and saturating integrator
  logic signed [13:0] p_nxt;
  logic signed [16:0] integ_sum;
  logic signed [15:0] integ_nxt;

  always_comb begin
    p_nxt     = 14'(err1) * 14'(signed'({1'b0, P_COEFF}));
    integ_sum = 17'(integ) + 17'(err1);
    integ_nxt = integ_sum[15:0];
    if (integ_sum > 17'sd32767)       integ_nxt = 16'sh7FFF;
    else if (integ_sum < -17'sd32768) integ_nxt = 16'sh8000;
  end

`ifdef HDNG_PID_DTERM_EN
  logic signed [9:0]  prev_err;
  logic signed [10:0] diff;
  logic signed [7:0]  diff_sat;
  logic signed [11:0] d_nxt;

  always_comb begin
    diff     = 11'(err1) - 11'(prev_err);
    diff_sat = diff[7:0];
    if (diff > 11'sd127)       diff_sat = 8'sd127;
    else if (diff < -11'sd128) diff_sat = -8'sd128;
    d_nxt    = 12'(diff_sat) * 12'(signed'({1'b0, D_COEFF}));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_err <= '0;
      d_reg    <= '0;
    end else if (v1) begin
      prev_err <= err1;
      d_reg    <= d_nxt;
    end
  end
`else
  // Derivative term absent; coefficient kept only so the parameter list is build-independent.
  assign d_reg = 12'(D_COEFF) & 12'h000;
`endif

  // Stage 3: combine terms and clamp symmetric wheel commands
  logic signed [13:0] sum;
  logic signed [10:0] pid;
  logic signed [12:0] lft_raw, rght_raw;

  function automatic logic [11:0] sat12(input logic signed [12:0] x);
    if (x > 13'sd2047)       return 12'h7FF;
    else if (x < -13'sd2047) return 12'h801;
    else                     return x[11:0];
  endfunction

  always_comb begin
    sum      = p_reg + 14'(d_reg) + 14'(signed'(integ[15:4]));
    pid      = mv2 ? 11'(sum >>> 3) : 11'sd0;
    lft_raw  = 13'(signed'({2'b00, f2})) + 13'(pid);
    rght_raw = 13'(signed'({2'b00, f2})) - 13'(pid);
  end

  // Each stage advances only on its valid token; forward speed travels with its sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      spd_vld  <= 1'b0;
      at_hdng  <= 1'b0;
      mv1      <= 1'b0;
      mv2      <= 1'b0;
      err1     <= '0;
      frwrd    <= '0;
      f2       <= '0;
      p_reg    <= '0;
      integ    <= '0;
      lft_spd  <= '0;
      rght_spd <= '0;
    end else begin
      v1      <= hdng_vld;
      v2      <= v1;
      spd_vld <= v2;
      if (hdng_vld) begin
        err1    <= err_sat;
        mv1     <= moving;
        at_hdng <= at_nxt;
        frwrd   <= frwrd_nxt;
      end
      if (v1) begin
        p_reg <= p_nxt;
        integ <= mv1 ? integ_nxt : 16'sd0;
        mv2   <= mv1;
        f2    <= frwrd;
      end
      if (v2) begin
        lft_spd  <= sat12(lft_raw);
        rght_spd <= sat12(rght_raw);
      end
    end
  end

endmodule

// File: tb/tb_hdng_pid.sv
// Directed self-checking bench for hdng_pid; expectations follow the HDNG_PID_DTERM_EN build setting.
module tb_hdng_pid;
  logic        clk = 1'b0;
  logic        rst, moving, hdng_vld;
  logic [11:0] dsrd_hdng, actl_hdng;
  logic [11:0] lft_spd, rght_spd;
  logic        spd_vld, at_hdng;
  int total = 0;
  int bad   = 0;

`ifdef HDNG_PID_DTERM_EN
  localparam logic [11:0] FS_L = 12'h02A, FS_R = 12'h006;
  localparam logic [11:0] WR_L = 12'hFF3, WR_R = 12'h03D;
  localparam logic [11:0] ST_L = 12'h13A, ST_R = 12'hEF6;
`else
  localparam logic [11:0] FS_L = 12'h01E, FS_R = 12'h012;
  localparam logic [11:0] WR_L = 12'h00B, WR_R = 12'h025;
  localparam logic [11:0] ST_L = 12'h0DB, ST_R = 12'hF55;
`endif

  hdng_pid dut (
    .clk(clk), .rst(rst), .moving(moving), .hdng_vld(hdng_vld),
    .dsrd_hdng(dsrd_hdng), .actl_hdng(actl_hdng),
    .lft_spd(lft_spd), .rght_spd(rght_spd), .spd_vld(spd_vld), .at_hdng(at_hdng)
  );

  always #5 clk = ~clk;

  // Short synchronous reset with no samples offered.
  task automatic reset_dut();
    @(negedge clk); rst = 1'b1; hdng_vld = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  // Offer one sample; returns at the negedge after stage 1 has captured it.
  task automatic send1(input logic mv, input logic [11:0] d, input logic [11:0] a);
    @(negedge clk); hdng_vld = 1'b1; moving = mv; dsrd_hdng = d; actl_hdng = a;
    @(negedge clk); hdng_vld = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; hdng_vld = 1'b1; moving = 1'b1;
    dsrd_hdng = 12'h000; actl_hdng = 12'h100;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if ({lft_spd, rght_spd, spd_vld, at_hdng} !== 26'd0) begin
        bad++;
        $display("FAIL reset_outputs: got l=%h r=%h v=%b a=%b, want all 0",
                 lft_spd, rght_spd, spd_vld, at_hdng);
      end
    end
    rst = 1'b0; hdng_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (spd_vld !== 1'b0) begin
        bad++; $display("FAIL reset_no_vld: cycle %0d got spd_vld=%b want 0", i, spd_vld);
      end
    end
  endtask

  task automatic test_first_sample();
    reset_dut();
    send1(1'b1, 12'h000, 12'h010);
    total++;
    if (at_hdng !== 1'b1 || spd_vld !== 1'b0) begin
      bad++; $display("FAIL first_n1: got at_hdng=%b spd_vld=%b want 1 0", at_hdng, spd_vld);
    end
    @(negedge clk);
    total++;
    if (spd_vld !== 1'b0) begin
      bad++; $display("FAIL first_n2: got spd_vld=%b want 0", spd_vld);
    end
    @(negedge clk);
    total++;
    if (spd_vld !== 1'b1 || lft_spd !== FS_L || rght_spd !== FS_R) begin
      bad++; $display("FAIL first_n3: got v=%b l=%h r=%h want 1 %h %h",
                      spd_vld, lft_spd, rght_spd, FS_L, FS_R);
    end
    @(negedge clk);
    total++;
    if (spd_vld !== 1'b0 || lft_spd !== FS_L || rght_spd !== FS_R) begin
      bad++; $display("FAIL first_hold: got v=%b l=%h r=%h want 0 %h %h",
                      spd_vld, lft_spd, rght_spd, FS_L, FS_R);
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    @(negedge clk); hdng_vld = 1'b1; moving = 1'b1; dsrd_hdng = 12'h000; actl_hdng = 12'h040;
    @(negedge clk); hdng_vld = 1'b1; actl_hdng = 12'h020;
    @(negedge clk); hdng_vld = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (spd_vld !== 1'b0 || lft_spd !== 12'h000) begin
        bad++; $display("FAIL mid_reset_drop: cycle %0d got v=%b l=%h want 0 000", i, spd_vld, lft_spd);
      end
    end
    send1(1'b1, 12'h000, 12'h010);
    repeat (2) @(negedge clk);
    total++;
    if (spd_vld !== 1'b1 || lft_spd !== FS_L || rght_spd !== FS_R) begin
      bad++; $display("FAIL mid_reset_restart: got v=%b l=%h r=%h want 1 %h %h",
                      spd_vld, lft_spd, rght_spd, FS_L, FS_R);
    end
  endtask

  task automatic test_wrap();
    reset_dut();
    send1(1'b1, 12'h810, 12'h7F0);
    total++;
    if (at_hdng !== 1'b1) begin
      bad++; $display("FAIL wrap_at_hdng: got %b want 1", at_hdng);
    end
    repeat (2) @(negedge clk);
    total++;
    if (spd_vld !== 1'b1 || lft_spd !== WR_L || rght_spd !== WR_R) begin
      bad++; $display("FAIL wrap_speed: got v=%b l=%h r=%h want 1 %h %h",
                      spd_vld, lft_spd, rght_spd, WR_L, WR_R);
    end
  endtask

  task automatic test_threshold();
    logic [11:0] errs [5] = '{12'h02F, 12'h030, 12'hFD0, 12'hFD1, 12'h800};
    logic        exps [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      send1(1'b1, 12'h000, errs[i]);
      total++;
      if (at_hdng !== exps[i]) begin
        bad++; $display("FAIL threshold: err=%h got at_hdng=%b want %b", errs[i], at_hdng, exps[i]);
      end
    end
  endtask

  task automatic test_saturation();
    reset_dut();
    send1(1'b1, 12'h000, 12'h400);
    total++;
    if (at_hdng !== 1'b0) begin
      bad++; $display("FAIL sat_at_hdng: got %b want 0", at_hdng);
    end
    repeat (2) @(negedge clk);
    total++;
    if (lft_spd !== ST_L || rght_spd !== ST_R) begin
      bad++; $display("FAIL sat_first: got l=%h r=%h want %h %h", lft_spd, rght_spd, ST_L, ST_R);
    end
    @(negedge clk); hdng_vld = 1'b1;
    repeat (68) @(negedge clk);
    hdng_vld = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (lft_spd !== 12'h45F || rght_spd !== 12'h0E1) begin
      bad++; $display("FAIL sat_integ: got l=%h r=%h want 45f 0e1", lft_spd, rght_spd);
    end
  endtask

  task automatic test_ramp();
    logic [11:0] exp_spd;
    reset_dut();
    @(negedge clk); hdng_vld = 1'b1; moving = 1'b1; dsrd_hdng = 12'h000; actl_hdng = 12'h000;
    repeat (40) @(negedge clk);
    hdng_vld = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (lft_spd !== 12'h2A0 || rght_spd !== 12'h2A0) begin
      bad++; $display("FAIL ramp_ceiling: got l=%h r=%h want 2a0 2a0", lft_spd, rght_spd);
    end
    for (int k = 1; k <= 16; k++) begin
      send1(1'b0, 12'h000, 12'h050);
      repeat (2) @(negedge clk);
      exp_spd = (k < 14) ? 12'(672 - 48 * k) : 12'h000;
      total++;
      if (spd_vld !== 1'b1 || lft_spd !== exp_spd || rght_spd !== exp_spd) begin
        bad++; $display("FAIL ramp_down: step %0d got v=%b l=%h r=%h want 1 %h %h",
                        k, spd_vld, lft_spd, rght_spd, exp_spd, exp_spd);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] errs [15];
    logic [11:0] spds [15];
    logic        ats  [15];
    for (int i = 0; i < 10; i++) begin
      errs[i] = 12'h000; spds[i] = 12'(24 * (i + 1)); ats[i] = 1'b1;
    end
    errs[10] = 12'h010; errs[11] = 12'h020; errs[12] = 12'h100; errs[13] = 12'hF00; errs[14] = 12'h7FF;
    spds[10] = 12'd192; spds[11] = 12'd144; spds[12] = 12'd96; spds[13] = 12'd48; spds[14] = 12'd0;
    ats[10] = 1'b1; ats[11] = 1'b1; ats[12] = 1'b0; ats[13] = 1'b0; ats[14] = 1'b0;
    reset_dut();
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 15) begin
        total++;
        if (at_hdng !== ats[c-1]) begin
          bad++; $display("FAIL b2b_at_hdng: sample %0d got %b want %b", c - 1, at_hdng, ats[c-1]);
        end
      end
      if (c >= 3 && c <= 17) begin
        total++;
        if (spd_vld !== 1'b1 || lft_spd !== spds[c-3] || rght_spd !== spds[c-3]) begin
          bad++; $display("FAIL b2b_speed: sample %0d got v=%b l=%h r=%h want 1 %h %h",
                          c - 3, spd_vld, lft_spd, rght_spd, spds[c-3], spds[c-3]);
        end
      end else if (c == 18) begin
        total++;
        if (spd_vld !== 1'b0) begin
          bad++; $display("FAIL b2b_end: got spd_vld=%b want 0", spd_vld);
        end
      end
      if (c < 15) begin
        hdng_vld = 1'b1; moving = (c < 10); dsrd_hdng = 12'h000; actl_hdng = errs[c];
      end else begin
        hdng_vld = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b0; moving = 1'b0; hdng_vld = 1'b0; dsrd_hdng = '0; actl_hdng = '0;
    test_reset();
    test_first_sample();
    test_reset_mid();
    test_wrap();
    test_threshold();
    test_saturation();
    test_ramp();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
